core_mem_s: RTL and testbench

Memory stage of the Selen core pipeline. It consumes the registered execute-stage outputs (ALU result, effective address, store data, the 7-bit L1D request bus, the ALU/MEM writeback select and the register-file write enable). It drives a valid/ack request and valid response handshake to the L1D cache. It stalls the pipeline while an access is outstanding and registers aligned, extended load data or the ALU result toward writeback.

---
 rtl/core_mem_s.sv | 231 +++++++++++++++++++++++
 tb/tb_core_mem_s.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/core_mem_s.sv
// core_mem_s -- memory stage of the Selen core pipeline.
//
// Takes the registered execute-stage outputs and runs one L1D access at a
// time over a valid/ack request and valid-only response handshake. Execute
// and earlier stages are stalled while an access is outstanding. Loads are
// lane-shifted and sign/zero-extended before they reach writeback.
//
// Ports
//   clk, rst_n                  core clock, async active-low reset
//   mem_alu_result_in           ALU result from execute
//   mem_addr_in                 effective address
//   mem_w_data_in               store data
//   mem_l1d_bus_in[6:0]         [0] val, [1] cop, [3:2] size, [4] unsigned
//   mem_mux_in                  1 = writeback takes memory data
//   mem_we_reg_file_in          register-file write enable
//   mem_rd_in                   destination register
//   mem_result_frm_m            bypass to execute (ALU result)
//   mem_stall_out               hold execute and earlier stages
//   mem_misalign_out            one-cycle misaligned-access pulse (optional)
//   l1d_req_*                   request channel to L1D
//   l1d_resp_val/_data          read response from L1D
//   mem_*_out_reg               writeback registers
//
// Build option CORE_MEM_MISALIGN_TRAP_EN: when defined, misaligned half/word
// accesses are dropped and flagged on mem_misalign_out. When undefined, the
// low address bits are masked to the access alignment and the access proceeds.
//
// state | meaning
// ------+----------------------------------------------------
// IDLE  | no access outstanding; ALU results flow to writeback
// REQ   | request presented to L1D, waiting for ack
// RESP  | load accepted, waiting for response data

module core_mem_s #(
    parameter int XLEN      = 32,
    parameter int L1D_BUS_W = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [XLEN-1:0]      mem_alu_result_in,
    input  logic [XLEN-1:0]      mem_addr_in,
    input  logic [XLEN-1:0]      mem_w_data_in,
    input  logic [L1D_BUS_W-1:0] mem_l1d_bus_in,
    input  logic                 mem_mux_in,
    input  logic                 mem_we_reg_file_in,
    input  logic [4:0]           mem_rd_in,
    output logic [XLEN-1:0]      mem_result_frm_m,
    output logic                 mem_stall_out,
`ifdef CORE_MEM_MISALIGN_TRAP_EN
    output logic                 mem_misalign_out,
`endif
    output logic                 l1d_req_val,
    input  logic                 l1d_req_ack,
    output logic                 l1d_req_cop,
    output logic [XLEN-1:0]      l1d_req_addr,
    output logic [XLEN-1:0]      l1d_req_wdata,
    output logic [3:0]           l1d_req_be,
    input  logic                 l1d_resp_val,
    input  logic [XLEN-1:0]      l1d_resp_data,
    output logic [XLEN-1:0]      mem_wb_data_out_reg,
    output logic                 mem_we_reg_file_out_reg,
    output logic [4:0]           mem_rd_out_reg
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t state, state_nxt;

    logic            req_val_in, cop_in, uns_in, issue;
    logic [1:0]      size_in, off_in;
    logic [3:0]      be_in;
    logic [XLEN-1:0] wdata_in, shifted, load_ext;

    logic            cap_cop, cap_uns, cap_we, cap_mux;
    logic [1:0]      cap_size, cap_off;
    logic [3:0]      cap_be;
    logic [4:0]      cap_rd;
    logic [XLEN-1:0] cap_addr, cap_wdata, cap_alu;

    logic unused_bus;
    assign unused_bus = ^mem_l1d_bus_in[6:5];

    assign req_val_in = mem_l1d_bus_in[0];
    assign cop_in     = mem_l1d_bus_in[1];
    assign size_in    = mem_l1d_bus_in[3:2];
    assign uns_in     = mem_l1d_bus_in[4];

    assign mem_result_frm_m = mem_alu_result_in;

    // Byte offset forced to the access alignment; reserved size acts as word.
    always_comb begin
        off_in   = 2'b00;
        be_in    = 4'b1111;
        wdata_in = mem_w_data_in;
        case (size_in)
            2'b00: begin
                off_in   = mem_addr_in[1:0];
                be_in    = 4'b0001 << mem_addr_in[1:0];
                wdata_in = {4{mem_w_data_in[7:0]}};
            end
            2'b01: begin
                off_in   = {mem_addr_in[1], 1'b0};
                be_in    = mem_addr_in[1] ? 4'b1100 : 4'b0011;
                wdata_in = {2{mem_w_data_in[15:0]}};
            end
            default: ;
        endcase
    end

`ifdef CORE_MEM_MISALIGN_TRAP_EN
    logic misalign_in;
    assign misalign_in = (size_in == 2'b01) ? mem_addr_in[0]
                       : (size_in != 2'b00) ? (mem_addr_in[1:0] != 2'b00)
                       : 1'b0;
    assign issue = req_val_in & ~misalign_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mem_misalign_out <= 1'b0;
        else        mem_misalign_out <= (state == IDLE) & req_val_in & misalign_in;
    end
`else
    assign issue = req_val_in;
`endif

    always_comb begin
        shifted = l1d_resp_data >> {cap_off, 3'b000};
        case (cap_size)
            2'b00:   load_ext = {{24{~cap_uns & shifted[7]}},  shifted[7:0]};
            2'b01:   load_ext = {{16{~cap_uns & shifted[15]}}, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    always_comb begin
        state_nxt     = state;
        mem_stall_out = 1'b0;
        l1d_req_val   = 1'b0;
        case (state)
            IDLE: begin
                if (issue) begin
                    mem_stall_out = 1'b1;
                    state_nxt     = REQ;
                end
            end
            REQ: begin
                l1d_req_val   = 1'b1;
                mem_stall_out = 1'b1;
                if (l1d_req_ack) begin
                    if (cap_cop) begin
                        mem_stall_out = 1'b0;
                        state_nxt     = IDLE;
                    end else begin
                        state_nxt = RESP;
                    end
                end
            end
            RESP: begin
                mem_stall_out = ~l1d_resp_val;
                if (l1d_resp_val) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    assign l1d_req_cop   = cap_cop;
    assign l1d_req_addr  = cap_addr;
    assign l1d_req_wdata = cap_wdata;
    assign l1d_req_be    = cap_be;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_cop                 <= 1'b0;
            cap_uns                 <= 1'b0;
            cap_we                  <= 1'b0;
            cap_mux                 <= 1'b0;
            cap_size                <= 2'b00;
            cap_off                 <= 2'b00;
            cap_be                  <= 4'b0000;
            cap_rd                  <= 5'd0;
            cap_addr                <= '0;
            cap_wdata               <= '0;
            cap_alu                 <= '0;
            mem_wb_data_out_reg     <= '0;
            mem_we_reg_file_out_reg <= 1'b0;
            mem_rd_out_reg          <= 5'd0;
        end else begin
            if (state == IDLE && issue) begin
                cap_cop   <= cop_in;
                cap_uns   <= uns_in;
                cap_we    <= mem_we_reg_file_in;
                cap_mux   <= mem_mux_in;
                cap_size  <= size_in;
                cap_off   <= off_in;
                cap_be    <= be_in;
                cap_rd    <= mem_rd_in;
                cap_addr  <= {mem_addr_in[XLEN-1:2], 2'b00};
                cap_wdata <= wdata_in;
                cap_alu   <= mem_alu_result_in;
            end
            case (state)
                IDLE: begin
                    // Any memory instruction (issued or trapped) leaves a bubble.
                    mem_wb_data_out_reg     <= mem_alu_result_in;
                    mem_we_reg_file_out_reg <= mem_we_reg_file_in & ~req_val_in;
                    mem_rd_out_reg          <= mem_rd_in;
                end
                REQ: begin
                    if (l1d_req_ack && cap_cop) begin
                        mem_wb_data_out_reg     <= cap_alu;
                        mem_we_reg_file_out_reg <= cap_we;
                        mem_rd_out_reg          <= cap_rd;
                    end
                end
                RESP: begin
                    if (l1d_resp_val) begin
                        mem_wb_data_out_reg     <= cap_mux ? load_ext : cap_alu;
                        mem_we_reg_file_out_reg <= cap_we;
                        mem_rd_out_reg          <= cap_rd;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_core_mem_s.sv
module tb_core_mem_s;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] alu_in, addr_in, wd_in;
    logic [6:0]  bus_in;
    logic        mux_in, we_in;
    logic [4:0]  rd_in;
    logic [31:0] result_frm_m;
    logic        stall;
    logic        req_val, req_ack, req_cop;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        resp_val;
    logic [31:0] resp_data;
    logic [31:0] wb_data;
    logic        wb_we;
    logic [4:0]  wb_rd;
`ifdef CORE_MEM_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    int n_stall;

    always #5 clk = ~clk;

    core_mem_s dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .mem_alu_result_in       (alu_in),
        .mem_addr_in             (addr_in),
        .mem_w_data_in           (wd_in),
        .mem_l1d_bus_in          (bus_in),
        .mem_mux_in              (mux_in),
        .mem_we_reg_file_in      (we_in),
        .mem_rd_in               (rd_in),
        .mem_result_frm_m        (result_frm_m),
        .mem_stall_out           (stall),
`ifdef CORE_MEM_MISALIGN_TRAP_EN
        .mem_misalign_out        (misalign),
`endif
        .l1d_req_val             (req_val),
        .l1d_req_ack             (req_ack),
        .l1d_req_cop             (req_cop),
        .l1d_req_addr            (req_addr),
        .l1d_req_wdata           (req_wdata),
        .l1d_req_be              (req_be),
        .l1d_resp_val            (resp_val),
        .l1d_resp_data           (resp_data),
        .mem_wb_data_out_reg     (wb_data),
        .mem_we_reg_file_out_reg (wb_we),
        .mem_rd_out_reg          (wb_rd)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", tag, got, exp);
    endtask

    task automatic drive(input logic [6:0] bus, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] alu, input logic we, input logic [4:0] rd,
                         input logic mux);
        bus_in  = bus;
        addr_in = addr;
        wd_in   = wd;
        alu_in  = alu;
        we_in   = we;
        rd_in   = rd;
        mux_in  = mux;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running, want finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        req_ack   = 1'b0;
        resp_val  = 1'b0;
        resp_data = '0;
        drive(7'b0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);

        // reset state
        @(negedge clk); #1;
        check("rst_stall",   stall,   0);
        check("rst_req_val", req_val, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_wb_we",   wb_we,   0);
        check("rst_wb_rd",   wb_rd,   0);
        rst_n = 1'b1;

        // ALU stream: 5 then 7 on consecutive cycles, bypass combinational
        @(negedge clk);
        drive(7'b0, 32'h0, 32'h0, 32'd5, 1'b1, 5'd4, 1'b0);
        #1 check("alu_stall", stall, 0);
        check("alu_bypass", result_frm_m, 32'd5);
        @(negedge clk); #1;
        check("alu_wb5", wb_data, 32'd5);
        check("alu_we5", wb_we, 1);
        check("alu_rd5", wb_rd, 5'd4);
        drive(7'b0, 32'h0, 32'h0, 32'd7, 1'b1, 5'd5, 1'b0);
        @(negedge clk); #1;
        check("alu_wb7", wb_data, 32'd7);
        check("alu_rd7", wb_rd, 5'd5);

        // store word 0x100, ack in third REQ cycle -> 3 stall cycles
        drive(7'b0001011, 32'h100, 32'hDEADBEEF, 32'h1111, 1'b0, 5'd3, 1'b0);
        #1 check("sw_stall_idle", stall, 1);
        n_stall = int'(stall);
        @(negedge clk);
        drive(7'b0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd0, 1'b0);
        #1 check("sw_req_val", req_val, 1);
        check("sw_addr",  req_addr,  32'h100);
        check("sw_be",    req_be,    4'b1111);
        check("sw_wdata", req_wdata, 32'hDEADBEEF);
        check("sw_cop",   req_cop,   1);
        check("sw_bubble", wb_we,    0);
        n_stall += int'(stall);
        @(negedge clk); #1;
        check("sw_hold_addr", req_addr, 32'h100);
        n_stall += int'(stall);
        @(negedge clk);
        req_ack = 1'b1;
        #1 check("sw_stall_ack", stall, 0);
        n_stall += int'(stall);
        @(negedge clk);
        req_ack = 1'b0;
        #1 check("sw_stall_cycles", n_stall, 3);
        check("sw_req_done", req_val, 0);
        check("sw_we_out", wb_we, 0);

        // store byte 0x101, immediate ack
        drive(7'b0000011, 32'h101, 32'h000000AB, 32'h0, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        drive(7'b0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
        req_ack = 1'b1;
        #1 check("sb_be",    req_be,    4'b0010);
        check("sb_wdata", req_wdata, 32'hABABABAB);
        check("sb_stall", stall, 0);
        @(negedge clk);
        req_ack = 1'b0;
        #1 check("sb_idle", req_val, 0);

        // load byte signed 0x203; resp with ack is ignored
        drive(7'b0000001, 32'h203, 32'h0, 32'h55, 1'b1, 5'd7, 1'b1);
        @(negedge clk);
        drive(7'b0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
        req_ack   = 1'b1;
        resp_val  = 1'b1;
        resp_data = 32'h12345678;
        #1 check("lb_addr", req_addr, 32'h200);
        check("lb_be",  req_be,   4'b1000);
        check("lb_cop", req_cop,  0);
        check("lb_stall_ack", stall, 1);
        @(negedge clk);
        req_ack  = 1'b0;
        resp_val = 1'b0;
        #1 check("lb_resp_req", req_val, 0);
        check("lb_resp_stall", stall, 1);
        check("lb_resp_we", wb_we, 0);
        @(negedge clk);
        resp_val  = 1'b1;
        resp_data = 32'h80112233;
        #1 check("lb_stall_drop", stall, 0);
        @(negedge clk);
        resp_val = 1'b0;
        #1 check("lb_data", wb_data, 32'hFFFFFF80);
        check("lb_we", wb_we, 1);
        check("lb_rd", wb_rd, 5'd7);

        // load half unsigned 0x202, response right after ack
        drive(7'b0010101, 32'h202, 32'h0, 32'h0, 1'b1, 5'd9, 1'b1);
        @(negedge clk);
        drive(7'b0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
        req_ack = 1'b1;
        #1 check("lhu_be", req_be, 4'b1100);
        check("lhu_addr", req_addr, 32'h200);
        @(negedge clk);
        req_ack   = 1'b0;
        resp_val  = 1'b1;
        resp_data = 32'hBEEF0000;
        #1 check("lhu_stall", stall, 0);
        @(negedge clk);
        resp_val = 1'b0;
        #1 check("lhu_data", wb_data, 32'h0000BEEF);
        check("lhu_rd", wb_rd, 5'd9);

        // word load at misaligned 0x102
        drive(7'b0001001, 32'h102, 32'h0, 32'h0, 1'b1, 5'd11, 1'b1);
`ifdef CORE_MEM_MISALIGN_TRAP_EN
        #1 check("mis_stall", stall, 0);
        @(negedge clk);
        drive(7'b0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
        #1 check("mis_pulse", misalign, 1);
        check("mis_req_val", req_val, 0);
        check("mis_we", wb_we, 0);
        @(negedge clk); #1;
        check("mis_pulse_end", misalign, 0);
`else
        @(negedge clk);
        drive(7'b0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
        req_ack = 1'b1;
        #1 check("mis_addr", req_addr, 32'h100);
        check("mis_be", req_be, 4'b1111);
        @(negedge clk);
        req_ack   = 1'b0;
        resp_val  = 1'b1;
        resp_data = 32'hCAFEF00D;
        @(negedge clk);
        resp_val = 1'b0;
        #1 check("mis_data", wb_data, 32'hCAFEF00D);
        check("mis_rd", wb_rd, 5'd11);
`endif

        // reset while in RESP, stray response afterwards
        drive(7'b0001001, 32'h300, 32'h0, 32'h0, 1'b1, 5'd2, 1'b1);
        @(negedge clk);
        drive(7'b0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
        req_ack = 1'b1;
        @(negedge clk);
        req_ack = 1'b0;
        #1 check("rr_in_resp", stall, 1);
        #1 rst_n = 1'b0;
        #1 check("rr_req_val", req_val, 0);
        check("rr_stall", stall, 0);
        check("rr_wb_data", wb_data, 0);
        check("rr_wb_rd",   wb_rd,   0);
        @(negedge clk);
        rst_n     = 1'b1;
        resp_val  = 1'b1;
        resp_data = 32'hAAAAAAAA;
        #1 check("rr_stray_stall", stall, 0);
        @(negedge clk);
        resp_val = 1'b0;
        #1 check("rr_stray_data", wb_data, 0);
        check("rr_stray_we", wb_we, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
